// File: rtl/apb3_fp2_mul_host_port.sv
// APB3 host port for the Fp2 Montgomery multiplier: packs 32-bit writes into operand digits,
// unpacks result entries into 32-bit reads, and tracks done/error status with an interrupt.
module apb3_fp2_mul_host_port #(
  parameter int RADIX      = 64,
  parameter int WORDS      = RADIX / 32,
  parameter int WIDTH_REAL = 4,
  parameter int RES_DEPTH  = (WIDTH_REAL + 1) / 2,
  localparam int AW  = (WIDTH_REAL > 1) ? $clog2(WIDTH_REAL) : 1,
  localparam int RAW = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1
) (
  input  logic               io_mainClk,
  input  logic               io_systemReset,
  input  logic               io_apb_PSEL,
  input  logic               io_apb_PENABLE,
  input  logic               io_apb_PWRITE,
  input  logic [7:0]         io_apb_PADDR,
  input  logic [31:0]        io_apb_PWDATA,
  output logic [31:0]        io_apb_PRDATA,
  output logic               io_apb_PREADY,
  output logic               io_apb_PSLVERROR,
  output logic               mult_start,
  output logic               mult_rst,
  input  logic               mult_done,
  input  logic               mult_busy,
  output logic [3:0]         op_wr_en,
  output logic [AW-1:0]      op_wr_addr,
  output logic [RADIX-1:0]   op_wr_data,
  output logic [1:0]         res_rd_en,
  output logic [RAW-1:0]     res_rd_addr_sub,
  output logic [RAW-1:0]     res_rd_addr_add,
  input  logic [2*RADIX-1:0] res_sub_dout,
  input  logic [2*RADIX-1:0] res_add_dout,
  output logic               irq
);
  localparam int WCW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int RCW = $clog2(2 * WORDS);
  localparam int SW  = (WORDS > 1) ? WORDS - 1 : 1;
  localparam logic [WCW-1:0] W_LAST   = WCW'(WORDS - 1);
  localparam logic [RCW-1:0] R_LAST   = RCW'(2 * WORDS - 1);
  localparam logic [AW-1:0]  OP_LAST  = AW'(WIDTH_REAL - 1);
  localparam logic [RAW-1:0] RES_LAST = RAW'(RES_DEPTH - 1);

  logic           wr, rd, ctrl_wr, stat_wr, rd_sub, rd_add;
  logic           op_hit, op_accept, op_blocked, op_switch, op_last, clear_all;
  logic [1:0]     op_idx;
  logic [WCW-1:0] wcnt_reg, stage_idx;
  logic [1:0]     cur_op_reg;
  logic [31:0]    stage_reg [SW];
  logic [AW-1:0]  ptr_reg [4];
  logic [RCW-1:0] rcnt_sub_reg, rcnt_add_reg;
  logic [RAW-1:0] addr_sub_reg, addr_add_reg;
  logic           done_sticky_reg, err_sticky_reg, irq_en_reg, irq_reg;
  logic           mult_start_reg, mult_rst_reg;
  logic [3:0]     op_wr_en_reg;
  logic [AW-1:0]  op_wr_addr_reg;
  logic [RADIX-1:0] op_wr_data_reg, digit_next;
  logic [1:0]     res_rd_en_reg;

  assign wr      = io_apb_PSEL & io_apb_PENABLE & io_apb_PWRITE;
  assign rd      = io_apb_PSEL & io_apb_PENABLE & ~io_apb_PWRITE;
  assign ctrl_wr = wr && (io_apb_PADDR == 8'h00);
  assign stat_wr = wr && (io_apb_PADDR == 8'h04);
  assign rd_sub  = rd && (io_apb_PADDR == 8'h20);
  assign rd_add  = rd && (io_apb_PADDR == 8'h24);

  always_comb begin
    op_hit = 1'b1;
    op_idx = 2'd0;
    case (io_apb_PADDR)
      8'h08:   op_idx = 2'd0;
      8'h0C:   op_idx = 2'd1;
      8'h10:   op_idx = 2'd2;
      8'h14:   op_idx = 2'd3;
      default: op_hit = 1'b0;
    endcase
  end

  assign op_blocked = wr & op_hit & mult_busy;
  assign op_accept  = wr & op_hit & ~mult_busy;
  // A write to a different operand mid-digit abandons the partial digit and restarts at word 0.
  assign op_switch  = op_accept && (wcnt_reg != '0) && (op_idx != cur_op_reg);
  assign op_last    = op_accept && !op_switch && (wcnt_reg == W_LAST);
  assign stage_idx  = op_switch ? '0 : wcnt_reg;
  assign clear_all  = mult_done | (ctrl_wr & (io_apb_PWDATA[0] | io_apb_PWDATA[2]));

  always_comb begin
    digit_next = '0;
    for (int k = 0; k < WORDS - 1; k++)
      digit_next[32*k +: 32] = stage_reg[k];
    digit_next[RADIX-32 +: 32] = io_apb_PWDATA;
  end

  genvar gi;
  generate
    for (gi = 0; gi < SW; gi++) begin : g_stage
      always_ff @(posedge io_mainClk or posedge io_systemReset) begin
        if (io_systemReset)
          stage_reg[gi] <= '0;
        else if (clear_all)
          stage_reg[gi] <= '0;
        else if (op_accept && !op_last && (int'(stage_idx) == gi))
          stage_reg[gi] <= io_apb_PWDATA;
      end
    end
    for (gi = 0; gi < 4; gi++) begin : g_ptr
      always_ff @(posedge io_mainClk or posedge io_systemReset) begin
        if (io_systemReset)
          ptr_reg[gi] <= '0;
        else if (clear_all)
          ptr_reg[gi] <= '0;
        else if (op_last && (int'(op_idx) == gi))
          ptr_reg[gi] <= (ptr_reg[gi] == OP_LAST) ? '0 : ptr_reg[gi] + 1'b1;
      end
    end
  endgenerate

  always_ff @(posedge io_mainClk or posedge io_systemReset) begin
    if (io_systemReset) begin
      wcnt_reg        <= '0;
      cur_op_reg      <= '0;
      rcnt_sub_reg    <= '0;
      rcnt_add_reg    <= '0;
      addr_sub_reg    <= '0;
      addr_add_reg    <= '0;
      done_sticky_reg <= 1'b0;
      err_sticky_reg  <= 1'b0;
      irq_en_reg      <= 1'b0;
      irq_reg         <= 1'b0;
      mult_start_reg  <= 1'b0;
      mult_rst_reg    <= 1'b0;
      op_wr_en_reg    <= '0;
      op_wr_addr_reg  <= '0;
      op_wr_data_reg  <= '0;
      res_rd_en_reg   <= '0;
    end else begin
      op_wr_en_reg   <= '0;
      res_rd_en_reg  <= '0;
      mult_start_reg <= ctrl_wr & io_apb_PWDATA[3] & ~mult_busy;
      mult_rst_reg   <= ctrl_wr & io_apb_PWDATA[2];
      irq_reg        <= done_sticky_reg & irq_en_reg;
      if (ctrl_wr)
        irq_en_reg <= io_apb_PWDATA[4];
      // Completion is set-dominant over a simultaneous W1C.
      if (mult_done)
        done_sticky_reg <= 1'b1;
      else if (stat_wr && io_apb_PWDATA[1])
        done_sticky_reg <= 1'b0;
      if (op_switch || op_blocked)
        err_sticky_reg <= 1'b1;
      else if (stat_wr && io_apb_PWDATA[2])
        err_sticky_reg <= 1'b0;

      if (clear_all) begin
        wcnt_reg     <= '0;
        cur_op_reg   <= '0;
        rcnt_sub_reg <= '0;
        rcnt_add_reg <= '0;
        addr_sub_reg <= '0;
        addr_add_reg <= '0;
      end else begin
        if (op_last) begin
          op_wr_en_reg[op_idx] <= 1'b1;
          op_wr_addr_reg       <= ptr_reg[op_idx];
          op_wr_data_reg       <= digit_next;
          wcnt_reg             <= '0;
        end else if (op_accept) begin
          wcnt_reg   <= stage_idx + 1'b1;
          cur_op_reg <= op_idx;
        end
        if (rd_sub) begin
          rcnt_sub_reg <= (rcnt_sub_reg == R_LAST) ? '0 : rcnt_sub_reg + 1'b1;
          if (rcnt_sub_reg == R_LAST) begin
            res_rd_en_reg[0] <= 1'b1;
            addr_sub_reg     <= (addr_sub_reg == RES_LAST) ? '0 : addr_sub_reg + 1'b1;
          end
        end
        if (rd_add) begin
          rcnt_add_reg <= (rcnt_add_reg == R_LAST) ? '0 : rcnt_add_reg + 1'b1;
          if (rcnt_add_reg == R_LAST) begin
            res_rd_en_reg[1] <= 1'b1;
            addr_add_reg     <= (addr_add_reg == RES_LAST) ? '0 : addr_add_reg + 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    io_apb_PRDATA = '0;
    if (rd) begin
      case (io_apb_PADDR)
        8'h00:   io_apb_PRDATA = {27'b0, irq_en_reg, 2'b0, done_sticky_reg, mult_busy};
        8'h04:   io_apb_PRDATA = {29'b0, err_sticky_reg, done_sticky_reg, mult_busy};
        8'h20:   io_apb_PRDATA = res_sub_dout[32*int'(rcnt_sub_reg) +: 32];
        8'h24:   io_apb_PRDATA = res_add_dout[32*int'(rcnt_add_reg) +: 32];
        default: io_apb_PRDATA = '0;
      endcase
    end
  end

  assign io_apb_PREADY    = 1'b1;
  assign io_apb_PSLVERROR = op_blocked;
  assign mult_start       = mult_start_reg;
  assign mult_rst         = mult_rst_reg;
  assign op_wr_en         = op_wr_en_reg;
  assign op_wr_addr       = op_wr_addr_reg;
  assign op_wr_data       = op_wr_data_reg;
  assign res_rd_en        = res_rd_en_reg;
  assign res_rd_addr_sub  = addr_sub_reg;
  assign res_rd_addr_add  = addr_add_reg;
  assign irq              = irq_reg;
endmodule

// File: tb/tb_apb3_fp2_mul_host_port.sv
// Scoreboard bench for apb3_fp2_mul_host_port at RADIX=64, WIDTH_REAL=4.
module tb_apb3_fp2_mul_host_port;
  logic         clk = 0;
  logic         rst = 1;
  logic         psel = 0, penable = 0, pwrite = 0;
  logic [7:0]   paddr = '0;
  logic [31:0]  pwdata = '0;
  logic [31:0]  prdata;
  logic         pready, pslverror;
  logic         mult_start, mult_rst, mult_done = 0, mult_busy = 0;
  logic [3:0]   op_wr_en;
  logic [1:0]   op_wr_addr;
  logic [63:0]  op_wr_data;
  logic [1:0]   res_rd_en;
  logic [0:0]   res_rd_addr_sub, res_rd_addr_add;
  logic [127:0] res_sub_dout = '0, res_add_dout = '0;
  logic         irq;

  logic [127:0] sub_mem [2];
  logic [127:0] add_mem [2];

  typedef struct {
    logic [3:0]  en;
    logic [1:0]  addr;
    logic [63:0] data;
  } wr_t;
  wr_t        wr_q[$];
  logic [1:0] rd_q[$];

  int   errors = 0;
  int   checks = 0;
  logic last_err;
  logic [31:0] rdata;

  always #5 clk = ~clk;

  apb3_fp2_mul_host_port dut (
    .io_mainClk(clk), .io_systemReset(rst),
    .io_apb_PSEL(psel), .io_apb_PENABLE(penable), .io_apb_PWRITE(pwrite),
    .io_apb_PADDR(paddr), .io_apb_PWDATA(pwdata), .io_apb_PRDATA(prdata),
    .io_apb_PREADY(pready), .io_apb_PSLVERROR(pslverror),
    .mult_start(mult_start), .mult_rst(mult_rst), .mult_done(mult_done), .mult_busy(mult_busy),
    .op_wr_en(op_wr_en), .op_wr_addr(op_wr_addr), .op_wr_data(op_wr_data),
    .res_rd_en(res_rd_en), .res_rd_addr_sub(res_rd_addr_sub), .res_rd_addr_add(res_rd_addr_add),
    .res_sub_dout(res_sub_dout), .res_add_dout(res_add_dout), .irq(irq)
  );

  // External result memories with one-cycle registered read.
  always @(posedge clk) begin
    res_sub_dout <= sub_mem[res_rd_addr_sub];
    res_add_dout <= add_mem[res_rd_addr_add];
  end

  always @(posedge clk) begin
    wr_t        e;
    logic [1:0] r;
    #1;
    if (op_wr_en !== 4'b0000) begin
      checks++;
      if (wr_q.size() == 0) begin
        errors++;
        $display("FAIL op_write_unexpected: got en=%b addr=%0d data=%h, required none", op_wr_en, op_wr_addr, op_wr_data);
      end else begin
        e = wr_q.pop_front();
        if (op_wr_en !== e.en || op_wr_addr !== e.addr || op_wr_data !== e.data) begin
          errors++;
          $display("FAIL op_write: got en=%b addr=%0d data=%h, required en=%b addr=%0d data=%h",
                   op_wr_en, op_wr_addr, op_wr_data, e.en, e.addr, e.data);
        end else
          $display("op write en=%b addr=%0d data=%h", op_wr_en, op_wr_addr, op_wr_data);
      end
    end
    if (res_rd_en !== 2'b00) begin
      checks++;
      if (rd_q.size() == 0) begin
        errors++;
        $display("FAIL res_rd_en_unexpected: got %b, required none", res_rd_en);
      end else begin
        r = rd_q.pop_front();
        if (res_rd_en !== r) begin
          errors++;
          $display("FAIL res_rd_en: got %b, required %b", res_rd_en, r);
        end else
          $display("result advance en=%b", res_rd_en);
      end
    end
  end

  task automatic apb_write(input logic [7:0] a, input logic [31:0] d, input logic done_in_access);
    @(negedge clk);
    psel = 1; penable = 0; pwrite = 1; paddr = a; pwdata = d;
    @(negedge clk);
    penable = 1;
    if (done_in_access) mult_done = 1;
    #1 last_err = pslverror;
    @(negedge clk);
    psel = 0; penable = 0; pwrite = 0; mult_done = 0;
  endtask

  task automatic apb_read(input logic [7:0] a, output logic [31:0] d);
    @(negedge clk);
    psel = 1; penable = 0; pwrite = 0; paddr = a;
    @(negedge clk);
    penable = 1;
    #1 d = prdata;
    @(negedge clk);
    psel = 0; penable = 0;
    $display("apb read addr=%h data=%h", a, d);
  endtask

  task automatic push_wr(input logic [3:0] en, input logic [1:0] addr, input logic [63:0] data);
    wr_t e;
    e.en = en; e.addr = addr; e.data = data;
    wr_q.push_back(e);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (pready !== 1'b1 || op_wr_en !== 4'b0 || irq !== 1'b0 || mult_start !== 1'b0 ||
        mult_rst !== 1'b0 || res_rd_en !== 2'b0 || op_wr_data !== 64'h0 || prdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: got pready=%b en=%b irq=%b start=%b rst=%b rd_en=%b data=%h prdata=%h, required 1 and zeros",
               pready, op_wr_en, irq, mult_start, mult_rst, res_rd_en, op_wr_data, prdata);
    end
    rst = 0;
    apb_read(8'h00, rdata);
    checks++;
    if (rdata !== 32'h0) begin errors++; $display("FAIL reset_ctrl: got %h, required 0", rdata); end
    apb_read(8'h04, rdata);
    checks++;
    if (rdata !== 32'h0) begin errors++; $display("FAIL reset_status: got %h, required 0", rdata); end
  endtask

  task automatic test_packer;
    for (int i = 0; i < 4; i++)
      push_wr(4'b0001, 2'(i), {32'h11 + 32'(2*i) + 32'h1, 32'h11 + 32'(2*i)});
    for (int i = 0; i < 8; i++)
      apb_write(8'h08, 32'h11 + 32'(i), 1'b0);
    // Pointer wraps back to 0 after WIDTH_REAL digits.
    push_wr(4'b0001, 2'd0, 64'hBBBB0002_AAAA0001);
    apb_write(8'h08, 32'hAAAA0001, 1'b0);
    apb_write(8'h08, 32'hBBBB0002, 1'b0);
    apb_read(8'h30, rdata);
    checks++;
    if (rdata !== 32'h0) begin errors++; $display("FAIL unmapped_read: got %h, required 0", rdata); end
  endtask

  task automatic test_switch;
    apb_write(8'h00, 32'h1, 1'b0);
    push_wr(4'b0001, 2'd0, 64'h000000A2_000000A1);
    apb_write(8'h08, 32'hA1, 1'b0);
    apb_write(8'h08, 32'hA2, 1'b0);
    apb_write(8'h08, 32'hA3, 1'b0);
    apb_write(8'h10, 32'hB1, 1'b0);
    apb_read(8'h04, rdata);
    checks++;
    if (rdata !== 32'h4) begin errors++; $display("FAIL switch_status: got %h, required 4", rdata); end
    push_wr(4'b0100, 2'd0, 64'h000000B2_000000B1);
    apb_write(8'h10, 32'hB2, 1'b0);
    apb_write(8'h04, 32'h4, 1'b0);
    apb_read(8'h04, rdata);
    checks++;
    if (rdata !== 32'h0) begin errors++; $display("FAIL err_w1c: got %h, required 0", rdata); end
  endtask

  task automatic test_busy;
    apb_write(8'h00, 32'h1, 1'b0);
    mult_busy = 1;
    apb_write(8'h10, 32'hC1, 1'b0);
    checks++;
    if (last_err !== 1'b1) begin errors++; $display("FAIL busy_slverr: got %b, required 1", last_err); end
    apb_write(8'h00, 32'h8, 1'b0);
    #1;
    checks++;
    if (mult_start !== 1'b0) begin errors++; $display("FAIL busy_start: got %b, required 0", mult_start); end
    apb_read(8'h04, rdata);
    checks++;
    if (rdata !== 32'h5) begin errors++; $display("FAIL busy_status: got %h, required 5", rdata); end
    mult_busy = 0;
    apb_write(8'h00, 32'h8, 1'b0);
    #1;
    checks++;
    if (mult_start !== 1'b1) begin errors++; $display("FAIL start_pulse: got %b, required 1", mult_start); end
    @(negedge clk); #1;
    checks++;
    if (mult_start !== 1'b0) begin errors++; $display("FAIL start_width: got %b, required 0", mult_start); end
    // Blocked word left no partial state: b0 digit assembles from the next two words.
    push_wr(4'b0100, 2'd0, 64'h000000D2_000000D1);
    apb_write(8'h10, 32'hD1, 1'b0);
    checks++;
    if (last_err !== 1'b0) begin errors++; $display("FAIL idle_slverr: got %b, required 0", last_err); end
    apb_write(8'h10, 32'hD2, 1'b0);
    apb_write(8'h04, 32'h4, 1'b0);
  endtask

  task automatic test_result;
    logic [31:0] exp_w;
    for (int e = 0; e < 2; e++) begin
      rd_q.push_back(2'b01);
      for (int j = 0; j < 4; j++) begin
        exp_w = 32'h11111111 * 32'(4*e + j + 1);
        apb_read(8'h20, rdata);
        checks++;
        if (rdata !== exp_w) begin
          errors++;
          $display("FAIL sub_word e%0d w%0d: got %h, required %h", e, j, rdata, exp_w);
        end
      end
      #1;
      checks++;
      if (res_rd_addr_sub !== 1'(e + 1) || res_rd_addr_add !== 1'b0) begin
        errors++;
        $display("FAIL sub_addr: got sub=%0d add=%0d, required sub=%0d add=0", res_rd_addr_sub, res_rd_addr_add, 1'(e + 1));
      end
    end
    apb_read(8'h24, rdata);
    checks++;
    if (rdata !== 32'hA0000001) begin errors++; $display("FAIL add_w0: got %h, required a0000001", rdata); end
    apb_read(8'h24, rdata);
    checks++;
    if (rdata !== 32'hA0000002) begin errors++; $display("FAIL add_w1: got %h, required a0000002", rdata); end
    apb_write(8'h00, 32'h1, 1'b0);
    apb_read(8'h24, rdata);
    checks++;
    if (rdata !== 32'hA0000001) begin errors++; $display("FAIL add_after_clear: got %h, required a0000001", rdata); end
  endtask

  task automatic test_irq;
    apb_write(8'h00, 32'h11, 1'b0);
    push_wr(4'b0001, 2'd0, 64'h000000E2_000000E1);
    apb_write(8'h08, 32'hE1, 1'b0);
    apb_write(8'h08, 32'hE2, 1'b0);
    apb_write(8'h08, 32'hE3, 1'b0);
    @(negedge clk); mult_done = 1;
    @(negedge clk); mult_done = 0;
    #1;
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_latency: got %b, required 0", irq); end
    @(negedge clk); #1;
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL irq_assert: got %b, required 1", irq); end
    apb_read(8'h00, rdata);
    checks++;
    if (rdata !== 32'h12) begin errors++; $display("FAIL ctrl_read: got %h, required 12", rdata); end
    apb_write(8'h04, 32'h2, 1'b0);
    @(negedge clk); #1;
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear: got %b, required 0", irq); end
    apb_write(8'h04, 32'h2, 1'b1);
    apb_read(8'h04, rdata);
    checks++;
    if (rdata !== 32'h2) begin errors++; $display("FAIL done_set_wins: got %h, required 2", rdata); end
    // Done cleared the a0 pointer and the E3 partial.
    push_wr(4'b0001, 2'd0, 64'h000000F2_000000F1);
    apb_write(8'h08, 32'hF1, 1'b0);
    apb_write(8'h08, 32'hF2, 1'b0);
  endtask

  task automatic test_async_reset;
    push_wr(4'b0001, 2'd1, 64'h00000062_00000061);
    apb_write(8'h08, 32'h61, 1'b0);
    apb_write(8'h08, 32'h62, 1'b0);
    apb_write(8'h08, 32'h63, 1'b0);
    @(negedge clk); #2;
    rst = 1;
    #1;
    checks++;
    if (irq !== 1'b0 || op_wr_addr !== 2'd0 || op_wr_data !== 64'h0 || op_wr_en !== 4'b0 || pready !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: got irq=%b addr=%0d data=%h en=%b pready=%b, required zeros and pready=1",
               irq, op_wr_addr, op_wr_data, op_wr_en, pready);
    end
    @(negedge clk);
    rst = 0;
    push_wr(4'b0001, 2'd0, 64'h00000072_00000071);
    apb_write(8'h08, 32'h71, 1'b0);
    apb_write(8'h08, 32'h72, 1'b0);
  endtask

  initial begin
    sub_mem[0] = 128'h44444444_33333333_22222222_11111111;
    sub_mem[1] = 128'h88888888_77777777_66666666_55555555;
    add_mem[0] = 128'hA0000004_A0000003_A0000002_A0000001;
    add_mem[1] = 128'hB0000004_B0000003_B0000002_B0000001;
    test_reset;
    test_packer;
    test_switch;
    test_busy;
    test_result;
    test_irq;
    test_async_reset;
    repeat (4) @(negedge clk);
    checks++;
    if (wr_q.size() != 0 || rd_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d writes and %0d advances pending, required 0", wr_q.size(), rd_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
